// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Latency: imem_we one cycle after a word's low byte, done one cycle after the last write.
// Backpressure: byte_ready drops during WRITE and in IDLE/DONE/ERR; bytes move only on valid & ready.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_full;
  logic        xfer;
  logic        idle_like;
  logic        last_word;
  logic        cnt_too_big;

  assign xfer      = byte_valid & byte_ready;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  // Length decision uses the low byte on the wire, so it is made in the same cycle it arrives.
  assign cnt_full    = {cnt[15:8], byte_in};
  assign cnt_too_big = 32'(cnt_full) > (32'd1 << ADDR_W);
  // Compared as addr+1 == N in 32 bits so N = 2^ADDR_W needs no wrap in the address counter.
  assign last_word   = (32'(imem_addr) + 32'd1) == 32'(cnt);

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_nxt = CNT_HI;
      end
      CNT_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = CNT_LO;
      end
      CNT_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          if (cnt_full == 16'd0)  state_nxt = DONE;
          else if (cnt_too_big)   state_nxt = ERR;
          else                    state_nxt = DATA_HI;
        end
      end
      DATA_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = WRITE;
      end
      WRITE: begin
        imem_we   = 1'b1;
        busy      = 1'b1;
        state_nxt = last_word ? DONE : DATA_HI;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = CNT_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nxt = CNT_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 16'd0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
    end else begin
      if (idle_like && start) begin
        imem_addr <= '0;
      end
      case (state)
        CNT_HI:  if (xfer) cnt[15:8] <= byte_in;
        CNT_LO:  if (xfer) cnt <= cnt_full;
        DATA_HI: if (xfer) imem_wdata[15:8] <= byte_in;
        DATA_LO: if (xfer) imem_wdata[7:0] <= byte_in;
        WRITE:   if (!last_word) imem_addr <= imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed write sequences, length limits, reset and start handling.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [15:0]       wd[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte_timeout byte=%0h byte_ready never rose", b);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    chk({tag, "_we"},    32'(imem_we),    0);
    chk({tag, "_addr"},  32'(imem_addr),  0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 0);
    chk({tag, "_hold"},  32'(cpu_hold),   1);
    chk({tag, "_busy"},  32'(busy),       0);
    chk({tag, "_done"},  32'(done),       0);
    chk({tag, "_error"}, 32'(error),      0);
  endtask

  initial begin
    int base;
    int bad;
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #1;
    chk_reset_vals("por");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_hold", 32'(cpu_hold), 1);
    chk("idle_ready", 32'(byte_ready), 0);

    // two-word load, valid held high
    base = wa.size();
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(byte_ready), 1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h41); send_byte(8'h0F);
    chk("w0_we", 32'(imem_we), 1);
    chk("w0_addr", 32'(imem_addr), 0);
    chk("w0_data", 32'(imem_wdata), 32'h410F);
    chk("w0_ready", 32'(byte_ready), 0);
    send_byte(8'h42); send_byte(8'h07);
    chk("w1_we", 32'(imem_we), 1);
    chk("w1_addr", 32'(imem_addr), 1);
    chk("w1_data", 32'(imem_wdata), 32'h4207);
    @(negedge clock);
    chk("ld2_done", 32'(done), 1);
    chk("ld2_hold", 32'(cpu_hold), 0);
    chk("ld2_busy", 32'(busy), 0);
    chk("ld2_we", 32'(imem_we), 0);
    chk("ld2_addr_kept", 32'(imem_addr), 1);
    chk("ld2_nwr", wa.size() - base, 2);
    repeat (3) @(negedge clock);
    chk("done_sticky", 32'(done), 1);

    // start from DONE, then an empty program
    pulse_start();
    chk("restart_done", 32'(done), 0);
    chk("restart_hold", 32'(cpu_hold), 1);
    chk("restart_addr", 32'(imem_addr), 0);
    base = wa.size();
    send_byte(8'h00); send_byte(8'h00);
    chk("n0_done", 32'(done), 1);
    chk("n0_nwr", wa.size() - base, 0);

    // byte_valid toggling, with a start pulse ignored mid-load
    pulse_start();
    base = wa.size();
    send_gap(8'h00); send_gap(8'h02);
    pulse_start();
    chk("busy_start_busy", 32'(busy), 1);
    chk("busy_start_ready", 32'(byte_ready), 1);
    send_gap(8'h41); send_gap(8'h0F);
    send_gap(8'h42); send_gap(8'h07);
    chk("tog_done", 32'(done), 1);
    chk("tog_nwr", wa.size() - base, 2);
    if (wa.size() - base == 2) begin
      chk("tog_a0", 32'(wa[base]), 0);
      chk("tog_d0", 32'(wd[base]), 32'h410F);
      chk("tog_a1", 32'(wa[base+1]), 1);
      chk("tog_d1", 32'(wd[base+1]), 32'h4207);
    end

    // oversize length N = 1025
    pulse_start();
    base = wa.size();
    send_byte(8'h04); send_byte(8'h01);
    chk("big_error", 32'(error), 1);
    chk("big_ready", 32'(byte_ready), 0);
    chk("big_hold", 32'(cpu_hold), 1);
    chk("big_busy", 32'(busy), 0);
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (3) @(negedge clock);
    byte_valid = 1'b0;
    chk("big_sticky", 32'(error), 1);
    chk("big_nwr", wa.size() - base, 0);

    // reset asserted while in DATA_LO
    pulse_start();
    chk("err_cleared", 32'(error), 0);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h12);
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", 32'(busy), 0);
    pulse_start();
    base = wa.size();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    chk("reload_addr", 32'(imem_addr), 0);
    chk("reload_data", 32'(imem_wdata), 32'hABCD);
    @(negedge clock);
    chk("reload_done", 32'(done), 1);

    // full-capacity load, N = 1024
    pulse_start();
    base = wa.size();
    send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = 16'hA500 ^ 16'(i);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    @(negedge clock);
    chk("full_done", 32'(done), 1);
    chk("full_addr", 32'(imem_addr), 1023);
    chk("full_nwr", wa.size() - base, 1024);
    bad = 0;
    if (wa.size() - base == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        if (wa[base+i] !== ADDR_W'(i) || wd[base+i] !== (16'hA500 ^ 16'(i))) bad++;
      end
    end
    chk("full_seq_bad", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W 16-bit words.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new program load; single-cycle pulse.
REQ-005 byte_in  input  8  serial program byte.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  16  instruction word to write.
REQ-011 cpu_hold  output  1  holds the CPU (PC at 0, no fetch) while high.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed successfully; sticky.
REQ-014 error  output  1  load rejected; sticky.

Function
REQ-015 The byte transfer SHALL occur on a rising edge where byte_valid and byte_ready are both 1; no byte is consumed otherwise.
REQ-016 The stream format SHALL be: count high byte, count low byte (N, unsigned 16-bit), then N words, each sent high byte first.
REQ-017 The states SHALL be IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-018 byte_ready SHALL be 1 only in CNT_HI, CNT_LO, DATA_HI, DATA_LO.
REQ-019 busy SHALL be 1 in CNT_HI through WRITE and 0 in IDLE, DONE, ERR.
REQ-020 start in IDLE, DONE or ERR SHALL move to CNT_HI next edge, clear done and error, set imem_addr=0, and keep cpu_hold=1; start while busy SHALL be ignored.
REQ-021 CNT_HI -> CNT_LO on transfer; CNT_LO -> next state on transfer, decided on the full 16-bit N.
REQ-022 From CNT_LO: N=0 -> DONE; N > 2^ADDR_W -> ERR; otherwise -> DATA_HI.
REQ-023 DATA_HI latches byte into imem_wdata[15:8] -> DATA_LO; DATA_LO latches imem_wdata[7:0] -> WRITE.
REQ-024 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr and imem_wdata stable; imem_we SHALL be 0 in every other state.
REQ-025 Leaving WRITE: if imem_addr = N-1 -> DONE with imem_addr unchanged, else imem_addr increments by 1 -> DATA_HI.
REQ-026 Latency: imem_we asserts in the cycle after the low-byte transfer; done asserts in the cycle after the last WRITE.
REQ-027 N = 2^ADDR_W SHALL be accepted; the last write goes to address 2^ADDR_W-1 with no address wrap.
REQ-028 DONE: done=1, cpu_hold=0, held until start or reset.
REQ-029 ERR: error=1, cpu_hold=1, byte_ready=0, held until start or reset.
REQ-030 In IDLE, cpu_hold SHALL be 1.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0.
REQ-032 Reset mid-load SHALL abort the load; words already written stay in memory; a new start is required.

Verification
REQ-033 start; bytes 00 02 41 0F 42 07 with byte_valid held high -> writes addr0=16'h410F, then addr1=16'h4207; then done=1, cpu_hold=0, busy=0.
REQ-034 start; bytes 00 00 -> DONE one edge after the CNT_LO transfer; imem_we never asserted.
REQ-035 start; bytes 04 01 (N=1025, ADDR_W=10) -> error=1, byte_ready=0, cpu_hold=1, no writes; bytes 04 00 instead -> 1024 writes, last to addr 1023, done=1.
REQ-036 Stream from REQ-033 with byte_valid toggling each cycle -> identical write sequence, no duplicate or dropped bytes.
REQ-037 reset_n pulsed low while in DATA_LO -> all outputs take the REQ-031 values without a clock edge; start then reloads from addr 0.
REQ-038 start pulsed in DATA_HI -> ignored, load continues; start in DONE -> done cleared, cpu_hold=1, new load from addr 0.
